// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared width, iteration count, FSM states and op codes for the multiply/divide unit
package multdiv_pkg;
  localparam int WIDTH = 32;
  localparam int ITER = WIDTH;
  localparam int CW = $clog2(ITER);
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  typedef enum logic {OP_MUL, OP_DIV} op_t;
endpackage

// File: rtl/multdiv_step.sv
// multdiv_step: one combinational Booth add/sub or restoring-division trial step
module multdiv_step
  import multdiv_pkg::*;
(
  input  op_t              op,
  input  logic [WIDTH:0]   hi,
  input  logic [WIDTH:0]   b,
  input  logic [1:0]       booth,
  input  logic             q_msb,
  output logic [WIDTH:0]   nxt,
  output logic             q_bit
);
  logic [WIDTH:0] r_sh, x, addend, sum;
  logic sub;
  always_comb begin
    r_sh = {hi[WIDTH-1:0], q_msb};
    x = op == OP_DIV ? r_sh : hi;
    sub = op == OP_DIV || booth == 2'b10;
    addend = sub ? ~b : booth == 2'b01 ? b : '0;
    sum = x + addend + {{WIDTH{1'b0}}, sub};
    q_bit = ~sum[WIDTH];
    // a negative trial difference restores the shifted remainder
    nxt = op == OP_DIV ? (sum[WIDTH] ? r_sh : sum) : sum;
  end
endmodule

// File: rtl/multdiv.sv
// multdiv: iterative signed 32-bit Booth multiplier / restoring divider with one-cycle ready pulse
module multdiv
  import multdiv_pkg::*;
(
  input  logic             clock,
  input  logic             ctrl_reset_n,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             data_busy
);
  state_t state, state_nx;
  op_t op;
  logic [CW-1:0] count;
  logic [WIDTH:0] hi, b, nxt;
  logic [WIDTH-1:0] lo, abs_a, abs_b;
  logic q_m1, neg, fault, q_bit, start;
  always_comb begin
    start = (state == IDLE || state == DONE) && (ctrl_MULT ^ ctrl_DIV);
    abs_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    abs_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    state_nx = start ? RUN :
               state == RUN ? (count == CW'(ITER-1) ? FIX : RUN) :
               state == FIX ? DONE : IDLE;
    data_busy = state == RUN || state == FIX;
  end
  multdiv_step u_step (
    .op    (op),
    .hi    (hi),
    .b     (b),
    .booth ({lo[0], q_m1}),
    .q_msb (lo[WIDTH-1]),
    .nxt   (nxt),
    .q_bit (q_bit)
  );
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      state <= IDLE;
      op <= OP_MUL;
      count <= '0;
      hi <= '0;
      b <= '0;
      lo <= '0;
      q_m1 <= 1'b0;
      neg <= 1'b0;
      fault <= 1'b0;
      data_result <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      state <= state_nx;
      data_resultRDY <= state == FIX;
      if (start) begin
        op <= ctrl_DIV ? OP_DIV : OP_MUL;
        count <= '0;
        hi <= '0;
        q_m1 <= 1'b0;
        lo <= ctrl_DIV ? abs_a : data_operandA;
        b <= ctrl_DIV ? {1'b0, abs_b} : {data_operandB[WIDTH-1], data_operandB};
        neg <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        fault <= data_operandB == '0 ||
                 (data_operandA == {1'b1, {(WIDTH-1){1'b0}}} && &data_operandB);
      end else if (state == RUN) begin
        // multiply shifts {hi,lo,q_m1} right arithmetically; divide shifts quotient bits in from the right
        count <= count + 1'b1;
        hi <= op == OP_DIV ? nxt : {nxt[WIDTH], nxt[WIDTH:1]};
        lo <= op == OP_DIV ? {lo[WIDTH-2:0], q_bit} : {nxt[0], lo[WIDTH-1:1]};
        q_m1 <= lo[0];
      end else if (state == FIX) begin
        data_result <= op == OP_MUL ? lo : fault ? '0 : neg ? -lo : lo;
        data_exception <= op == OP_MUL ? hi[WIDTH-1:0] != {WIDTH{lo[WIDTH-1]}} : fault;
      end
    end
  end
endmodule

// File: tb/tb_multdiv.sv
// tb_multdiv: directed self-checking bench for the multdiv multiply/divide unit
module tb_multdiv;
  logic clock = 1'b0;
  logic ctrl_reset_n = 1'b0;
  logic [31:0] data_operandA = '0, data_operandB = '0;
  logic ctrl_MULT = 1'b0, ctrl_DIV = 1'b0;
  logic [31:0] data_result;
  logic data_exception, data_resultRDY, data_busy;
  int checks = 0, failures = 0;

  multdiv dut (
    .clock          (clock),
    .ctrl_reset_n   (ctrl_reset_n),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .data_busy      (data_busy)
  );

  always #5 clock = ~clock;

  // returns just after the accepting edge, with operands scrambled so late changes are exercised
  task automatic start_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] bb);
    @(negedge clock);
    data_operandA = a;
    data_operandB = bb;
    ctrl_MULT = m;
    ctrl_DIV = d;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    data_operandA = 32'hDEADBEEF;
    data_operandB = 32'h0BADF00D;
  endtask

  task automatic wait_rdy(output int cyc, output logic ok, output int busy_n);
    ok = 1'b0;
    cyc = 0;
    busy_n = data_busy ? 1 : 0;
    for (int i = 1; i <= 40 && !ok; i++) begin
      @(posedge clock);
      #1;
      if (data_busy) busy_n++;
      if (data_resultRDY) begin
        ok = 1'b1;
        cyc = i;
      end
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (data_result !== 32'h0 || data_exception !== 1'b0 || data_resultRDY !== 1'b0 || data_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got res=%h exc=%b rdy=%b busy=%b, want all zero",
               data_result, data_exception, data_resultRDY, data_busy);
    end
    @(negedge clock);
    ctrl_reset_n = 1'b1;
  endtask

  task automatic test_mult();
    logic [31:0] va [4];
    logic [31:0] vb [4];
    logic [31:0] vr [4];
    logic ve [4];
    int cyc, busy_n;
    logic ok;
    va = '{32'd6, 32'hFFFFFFFD, 32'h00010000, 32'h80000000};
    vb = '{32'd7, 32'd3, 32'h00010000, 32'hFFFFFFFF};
    vr = '{32'd42, 32'hFFFFFFF7, 32'h0, 32'h80000000};
    ve = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      start_op(1'b1, 1'b0, va[i], vb[i]);
      wait_rdy(cyc, ok, busy_n);
      checks++;
      if (!ok || cyc != 33) begin
        failures++;
        $display("FAIL mult%0d_latency: got rdy=%b after %0d cycles, want 33", i, ok, cyc);
      end
      checks++;
      if (data_result !== vr[i] || data_exception !== ve[i]) begin
        failures++;
        $display("FAIL mult%0d_result: got %h exc=%b, want %h exc=%b", i, data_result, data_exception, vr[i], ve[i]);
      end
      if (i == 0) begin
        checks++;
        if (busy_n != 33) begin
          failures++;
          $display("FAIL mult_busy_cycles: got %0d, want 33", busy_n);
        end
      end
      @(posedge clock);
      #1;
      checks++;
      if (data_resultRDY !== 1'b0 || data_result !== vr[i]) begin
        failures++;
        $display("FAIL mult%0d_rdy_once: got rdy=%b res=%h, want rdy=0 res=%h", i, data_resultRDY, data_result, vr[i]);
      end
    end
  endtask

  task automatic test_div();
    logic [31:0] va [5];
    logic [31:0] vb [5];
    logic [31:0] vr [5];
    logic ve [5];
    int cyc, busy_n;
    logic ok;
    va = '{32'hFFFFFFF9, 32'd100, 32'h80000000, 32'd5, 32'h80000000};
    vb = '{32'd2, 32'hFFFFFFF8, 32'd2, 32'd0, 32'hFFFFFFFF};
    vr = '{32'hFFFFFFFD, 32'hFFFFFFF4, 32'hC0000000, 32'h0, 32'h0};
    ve = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      start_op(1'b0, 1'b1, va[i], vb[i]);
      wait_rdy(cyc, ok, busy_n);
      checks++;
      if (!ok || cyc != 33) begin
        failures++;
        $display("FAIL div%0d_latency: got rdy=%b after %0d cycles, want 33", i, ok, cyc);
      end
      checks++;
      if (data_result !== vr[i] || data_exception !== ve[i]) begin
        failures++;
        $display("FAIL div%0d_result: got %h exc=%b, want %h exc=%b", i, data_result, data_exception, vr[i], ve[i]);
      end
    end
  endtask

  task automatic test_control();
    int cyc, busy_n;
    logic ok;
    start_op(1'b1, 1'b0, 32'd5, 32'd5);
    repeat (4) @(posedge clock);
    #1;
    data_operandA = 32'd9;
    data_operandB = 32'd9;
    ctrl_MULT = 1'b1;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    wait_rdy(cyc, ok, busy_n);
    checks++;
    if (!ok || cyc != 28 || data_result !== 32'd25 || data_exception !== 1'b0) begin
      failures++;
      $display("FAIL start_in_run: got rdy=%b cyc=%0d res=%h exc=%b, want rdy=1 cyc=28 res=00000019 exc=0",
               ok, cyc, data_result, data_exception);
    end
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b1;
    ctrl_DIV = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      checks++;
      if (data_busy !== 1'b0 || data_resultRDY !== 1'b0) begin
        failures++;
        $display("FAIL both_starts%0d: got busy=%b rdy=%b, want 0 0", i, data_busy, data_resultRDY);
      end
    end
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
  endtask

  task automatic test_back_to_back();
    int cyc, busy_n;
    logic ok;
    start_op(1'b0, 1'b1, 32'd100, 32'd7);
    wait_rdy(cyc, ok, busy_n);
    checks++;
    if (!ok || data_result !== 32'd14 || data_exception !== 1'b0) begin
      failures++;
      $display("FAIL b2b_first: got rdy=%b res=%h exc=%b, want rdy=1 res=0000000e exc=0", ok, data_result, data_exception);
    end
    start_op(1'b1, 1'b0, 32'hFFFFFFFC, 32'hFFFFFFFB);
    checks++;
    if (data_busy !== 1'b1 || data_resultRDY !== 1'b0) begin
      failures++;
      $display("FAIL b2b_accept_in_done: got busy=%b rdy=%b, want 1 0", data_busy, data_resultRDY);
    end
    wait_rdy(cyc, ok, busy_n);
    checks++;
    if (!ok || cyc != 33 || data_result !== 32'd20 || data_exception !== 1'b0) begin
      failures++;
      $display("FAIL b2b_second: got rdy=%b cyc=%0d res=%h exc=%b, want rdy=1 cyc=33 res=00000014 exc=0",
               ok, cyc, data_result, data_exception);
    end
  endtask

  task automatic test_reset_mid_op();
    int rdy_n, busy_n;
    start_op(1'b1, 1'b0, 32'h00010000, 32'h00010000);
    repeat (10) @(posedge clock);
    #1;
    ctrl_reset_n = 1'b0;
    #1;
    checks++;
    if (data_result !== 32'h0 || data_exception !== 1'b0 || data_resultRDY !== 1'b0 || data_busy !== 1'b0) begin
      failures++;
      $display("FAIL midop_reset_outputs: got res=%h exc=%b rdy=%b busy=%b, want all zero",
               data_result, data_exception, data_resultRDY, data_busy);
    end
    @(negedge clock);
    ctrl_reset_n = 1'b1;
    rdy_n = 0;
    busy_n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) rdy_n++;
      if (data_busy) busy_n++;
    end
    checks++;
    if (rdy_n != 0 || busy_n != 0) begin
      failures++;
      $display("FAIL midop_no_rdy: got %0d rdy and %0d busy cycles, want 0 0", rdy_n, busy_n);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_control();
    test_back_to_back();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
